// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin whole-burst arbiter (write/read) in front of one HyperRAM controller; `define PSRAM_ARB_STATS_EN adds burst/wait statistics
module psram_arbiter #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req_valid,
    input  logic [ADDR_W-1:0] wr_req_addr,
    output logic              wr_req_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_ready,
    input  logic              rd_req_valid,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_cmd_ready,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    input  logic              mem_done,
    output logic              busy,
    output logic              err
`ifdef PSRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_wr_bursts,
    output logic [15:0]       stat_rd_bursts,
    output logic [15:0]       stat_max_wait
`endif
);
    localparam int BCW = $clog2(BURST_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] BL_C  = BCW'(BURST_LEN);
    localparam logic [TW-1:0]  TMO_C = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state, state_n;
    logic              we, last_wr, pick_wr, any_req, wr_gate, rd_gate, tmo_hit, fault;
    logic [ADDR_W-1:0] addr;
    logic [BCW-1:0]    beat_cnt, cnt_n;
    logic [TW-1:0]     tmo_cnt;

    always_comb begin
        any_req       = wr_req_valid || rd_req_valid;
        pick_wr       = wr_req_valid && (!rd_req_valid || !last_wr);
        wr_gate       = state == DATA && we && beat_cnt < BL_C;
        rd_gate       = state == DATA && !we && beat_cnt < BL_C;
        wr_data_ready = wr_gate && mem_wr_ready;
        mem_wr_data   = wr_gate ? wr_data : '0;
        rd_data_valid = rd_gate && mem_rd_valid;
        rd_data       = rd_gate ? mem_rd_data : '0;
        cnt_n         = beat_cnt + BCW'(wr_data_ready || rd_data_valid);
        tmo_hit       = tmo_cnt + TW'(1) == TMO_C;
        fault         = state == DATA && (mem_done ? cnt_n != BL_C : tmo_hit);
        mem_cmd_valid = state == CMD;
        mem_cmd_we    = mem_cmd_valid && we;
        mem_cmd_addr  = mem_cmd_valid ? addr : '0;
        busy          = state != IDLE;
        state_n       = state;
        case (state)
            IDLE:    if (any_req) state_n = CMD;
            CMD:     if (mem_cmd_ready) state_n = DATA;
            DATA:    if (mem_done || tmo_hit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we           <= 1'b0;
            last_wr      <= 1'b1;
            addr         <= '0;
            beat_cnt     <= '0;
            tmo_cnt      <= '0;
            err          <= 1'b0;
            wr_req_ready <= 1'b0;
            rd_req_ready <= 1'b0;
        end else begin
            state        <= state_n;
            wr_req_ready <= state == IDLE && pick_wr;
            rd_req_ready <= state == IDLE && any_req && !pick_wr;
            if (state == IDLE && any_req) begin
                we      <= pick_wr;
                last_wr <= pick_wr;
                addr    <= pick_wr ? wr_req_addr : rd_req_addr;
            end
            if (state == CMD) begin
                beat_cnt <= '0;
                tmo_cnt  <= '0;
            end
            if (state == DATA) begin
                beat_cnt <= cnt_n;
                tmo_cnt  <= tmo_cnt + TW'(1);
            end
            if (fault) err <= 1'b1;
        end
    end

`ifdef PSRAM_ARB_STATS_EN
    logic        wr_acc, rd_acc, wr_waiting, rd_waiting;
    logic [15:0] wr_wait, rd_wait, peak;

    always_comb begin
        wr_acc     = state == IDLE && pick_wr;
        rd_acc     = state == IDLE && any_req && !pick_wr;
        wr_waiting = wr_req_valid && !(busy && we);
        rd_waiting = rd_req_valid && !(busy && !we);
        peak       = wr_acc ? wr_wait : rd_acc ? rd_wait : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_bursts <= '0;
            stat_rd_bursts <= '0;
            stat_max_wait  <= '0;
            wr_wait        <= '0;
            rd_wait        <= '0;
        end else begin
            if (state == CMD && mem_cmd_ready && we && stat_wr_bursts != '1) stat_wr_bursts <= stat_wr_bursts + 16'd1;
            if (state == CMD && mem_cmd_ready && !we && stat_rd_bursts != '1) stat_rd_bursts <= stat_rd_bursts + 16'd1;
            if (peak > stat_max_wait) stat_max_wait <= peak;
            wr_wait <= wr_acc ? '0 : (wr_waiting && wr_wait != '1) ? wr_wait + 16'd1 : wr_wait;
            rd_wait <= rd_acc ? '0 : (rd_waiting && rd_wait != '1) ? rd_wait + 16'd1 : rd_wait;
        end
    end
`endif
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized directed bench for psram_arbiter against a transaction-level model
module tb_psram_arbiter;
    localparam int BL  = 16;
    localparam int TMO = 1023;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_req_valid = 1'b0, rd_req_valid = 1'b0;
    logic [22:0] wr_req_addr = '0, rd_req_addr = '0;
    logic [7:0]  wr_data = '0, mem_rd_data = '0;
    logic        mem_cmd_ready = 1'b0, mem_wr_ready = 1'b0, mem_rd_valid = 1'b0, mem_done = 1'b0;
    logic        wr_req_ready, rd_req_ready, wr_data_ready, rd_data_valid;
    logic        mem_cmd_valid, mem_cmd_we, busy, err;
    logic [22:0] mem_cmd_addr;
    logic [7:0]  rd_data, mem_wr_data;

    int   total = 0, bad = 0;
    bit   last_we = 1'b1;
    bit   err_m = 1'b0;
    logic [22:0] wa, ra;

    psram_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_ready(wr_req_ready),
        .wr_data(wr_data), .wr_data_ready(wr_data_ready),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_ready(mem_cmd_ready), .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_done(mem_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant rule: lone requester wins; on a tie the port not served last wins.
    function automatic bit expect_we();
        return (wr_req_valid && rd_req_valid) ? !last_we : wr_req_valid;
    endfunction

    // Entered at a negedge in IDLE with requests driven; returns at the negedge of the first DATA cycle.
    task automatic accept(input bit hold);
        bit e;
        int k;
        e = expect_we();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wr_req_ready", wr_req_ready, e);
        chk("rd_req_ready", rd_req_ready, !e);
        chk("cmd_valid", mem_cmd_valid, 1);
        chk("cmd_we", mem_cmd_we, e);
        chk("cmd_addr", mem_cmd_addr, e ? wa : ra);
        last_we = e;
        if (!hold) begin
            if (e) wr_req_valid = 1'b0;
            else rd_req_valid = 1'b0;
        end
        k = $urandom_range(0, 2);
        repeat (k) begin
            @(negedge clk);
            #1;
            chk("ready_pulse", wr_req_ready | rd_req_ready, 0);
            chk("cmd_hold", mem_cmd_valid, 1);
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
    endtask

    // Offers beats to the current burst; optionally finishes with mem_done and checks the IDLE return.
    task automatic data(input bit we, input int offer, input bit gaps, input bit done);
        int   sent, fwd, seen;
        bit   b, f;
        logic [7:0] d;
        sent = 0; fwd = 0; seen = 0;
        while (sent < offer) begin
            b = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = 8'($urandom);
            if (we) begin mem_wr_ready = b; wr_data = d; end
            else begin mem_rd_valid = b; mem_rd_data = d; end
            #1;
            f = b && fwd < BL;
            if (we) begin
                chk("wr_data_ready", wr_data_ready, f);
                if (f) chk("mem_wr_data", mem_wr_data, d);
                chk("rd_valid_idle", rd_data_valid, 0);
                seen += int'(wr_data_ready);
            end else begin
                chk("rd_data_valid", rd_data_valid, f);
                if (f) chk("rd_data", rd_data, d);
                chk("wr_ready_idle", wr_data_ready, 0);
                seen += int'(rd_data_valid);
            end
            if (b) sent++;
            if (f) fwd++;
            @(negedge clk);
        end
        mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0;
        chk("beat_count", seen, fwd);
        if (done) begin
            mem_done = 1'b1;
            @(negedge clk);
            mem_done = 1'b0;
            #1;
            err_m = err_m | (fwd != BL);
            chk("busy_after_done", busy, 0);
            chk("err", err, err_m);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_wr_req_ready", wr_req_ready, 0);
        chk("rst_rd_req_ready", rd_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        wa = 23'($urandom); ra = 23'($urandom);
        wr_req_addr = wa; rd_req_addr = ra;
        wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        repeat (6) begin
            accept(1'b1);
            data(last_we, BL + $urandom_range(0, 2), 1'b1, 1'b1);
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        @(negedge clk);

        wa = 23'h000100; wr_req_addr = wa; wr_req_valid = 1'b1;
        #1;
        chk("ready_not_early", wr_req_ready, 0);
        accept(1'b0);
        data(1'b1, BL, 1'b0, 1'b1);

        ra = 23'($urandom); rd_req_addr = ra; rd_req_valid = 1'b1;
        accept(1'b0);
        data(1'b0, BL, 1'b1, 1'b1);

        wa = 23'($urandom); wr_req_addr = wa; wr_req_valid = 1'b1;
        accept(1'b0);
        data(1'b1, 12, 1'b1, 1'b1);
        ra = 23'($urandom); rd_req_addr = ra; rd_req_valid = 1'b1;
        accept(1'b0);
        data(1'b0, BL, 1'b1, 1'b1);

        wa = 23'($urandom); wr_req_addr = wa; wr_req_valid = 1'b1;
        accept(1'b0);
        ra = 23'($urandom); rd_req_addr = ra; rd_req_valid = 1'b1;
        n = 0;
        while (n < 2000) begin
            #1;
            n++;
            if (!busy) break;
            @(negedge clk);
        end
        chk("timeout_cycles", n - 1, TMO);
        err_m = 1'b1;
        chk("timeout_err", err, 1);
        accept(1'b0);
        data(1'b0, BL, 1'b1, 1'b1);

        ra = 23'($urandom); rd_req_addr = ra; rd_req_valid = 1'b1;
        accept(1'b1);
        data(1'b0, 5, 1'b0, 1'b0);
        mem_rd_valid = 1'b1; mem_rd_data = 8'hA5;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd_valid", rd_data_valid, 0);
        chk("arst_cmd_valid", mem_cmd_valid, 0);
        chk("arst_err", err, 0);
        err_m = 1'b0;
        last_we = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        rst = 1'b0;
        accept(1'b0);
        data(1'b0, BL, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
